// File: rtl/cpu_pkg.sv
// Shared CPU definitions: architectural widths, the canonical NOP and the fetch-queue entry.
package cpu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ROM_AW = 10;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue: two entries pushed together, zero to two popped per cycle, with flush.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               push_i,
    input  fetch_entry_t       wdata0_i,
    input  fetch_entry_t       wdata1_i,
    input  logic [1:0]         pop_cnt_i,
    output fetch_entry_t       rdata0_o,
    output fetch_entry_t       rdata1_o,
    output logic [CntW-1:0]    count_o
);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_nxt;
    logic [PtrW-1:0] rd_ptr_nxt;

    assign wr_ptr_nxt = wr_ptr_q + PtrW'(1);
    assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PtrW'(pop_cnt_i);
            wr_ptr_d = wr_ptr_q + (push_i ? PtrW'(2) : PtrW'(0));
            count_d  = count_q + (push_i ? CntW'(2) : CntW'(0)) - CntW'(pop_cnt_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; entries are only observable through count_o.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q]   <= wdata0_i;
            mem_q[wr_ptr_nxt] <= wdata1_i;
        end
    end

    assign rdata0_o = mem_q[rd_ptr_q];
    assign rdata1_o = mem_q[rd_ptr_nxt];
    assign count_o  = count_q;

endmodule

// File: rtl/dual_fetch.sv
// Dual-issue fetch stage: owns the fetch PC, issues paired ROM reads and feeds decode from a queue.
module dual_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned     QDEPTH   = 8,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [XLEN-1:0]   rom_instr1,
    input  logic [XLEN-1:0]   rom_instr2,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              dec_ready,
    output logic              dec_valid0,
    output logic              dec_valid1,
    output logic [XLEN-1:0]   dec_instr0,
    output logic [XLEN-1:0]   dec_instr1,
    output logic [XLEN-1:0]   dec_pc0,
    output logic [XLEN-1:0]   dec_pc1
);

    localparam int unsigned CntW = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            req_valid_q, req_valid_d;

    logic [CntW-1:0] count;
    logic [CntW+1:0] need;
    logic            issue;
    logic            push;
    logic [1:0]      pop_cnt;
    fetch_entry_t    wdata0, wdata1, head0, head1;

    // Credit check reserves room for the in-flight pair; pops in this cycle are not counted.
    assign need  = (CntW+2)'(count) + (req_valid_q ? (CntW+2)'(2) : '0) + (CntW+2)'(2);
    assign issue = !redirect_valid && (need <= (CntW+2)'(QDEPTH));
    assign push  = req_valid_q && !redirect_valid;

    assign wdata0 = '{pc: req_pc_q,             instr: rom_instr1};
    assign wdata1 = '{pc: req_pc_q + XLEN'(4), instr: rom_instr2};

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
        end else if (issue) begin
            req_valid_d = 1'b1;
            req_pc_d    = fetch_pc_q;
            fetch_pc_d  = fetch_pc_q + XLEN'(8);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

    fetch_queue #(
        .Depth (QDEPTH)
    ) u_queue (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .flush_i   (redirect_valid),
        .push_i    (push),
        .wdata0_i  (wdata0),
        .wdata1_i  (wdata1),
        .pop_cnt_i (pop_cnt),
        .rdata0_o  (head0),
        .rdata1_o  (head1),
        .count_o   (count)
    );

    always_comb begin
        dec_valid0 = (count >= CntW'(1)) && !redirect_valid;
        dec_valid1 = (count >= CntW'(2)) && !redirect_valid;
        pop_cnt    = 2'd0;
        if (dec_ready && dec_valid0) begin
            pop_cnt = dec_valid1 ? 2'd2 : 2'd1;
        end
        dec_instr0 = dec_valid0 ? head0.instr : NOP_INSTR;
        dec_instr1 = dec_valid1 ? head1.instr : NOP_INSTR;
        dec_pc0    = dec_valid0 ? head0.pc : '0;
        dec_pc1    = dec_valid1 ? head1.pc : '0;
    end

    assign rom_addr = fetch_pc_q[ROM_AW+1:2];

endmodule

// File: tb/tb_dual_fetch.sv
// Bench for dual_fetch: queue-level reference model checked every cycle plus directed literal checks.
module tb_dual_fetch;
    import cpu_pkg::*;

    localparam int unsigned QD = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rom_addr;
    logic [31:0] rom_instr1, rom_instr2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        dec_valid0, dec_valid1;
    logic [31:0] dec_instr0, dec_instr1, dec_pc0, dec_pc1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dual_fetch #(
        .QDEPTH   (QD),
        .RESET_PC (32'h0)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_instr1     (rom_instr1),
        .rom_instr2     (rom_instr2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .dec_valid0     (dec_valid0),
        .dec_valid1     (dec_valid1),
        .dec_instr0     (dec_instr0),
        .dec_instr1     (dec_instr1),
        .dec_pc0        (dec_pc0),
        .dec_pc1        (dec_pc1)
    );

    // Synchronous ROM returning word a and a+1 (mod 1024) one cycle after the address.
    logic [31:0] rom [1024];
    logic [9:0]  rom_addr_p1;
    assign rom_addr_p1 = rom_addr + 10'd1;
    always @(posedge clk) begin
        rom_instr1 <= rom[rom_addr];
        rom_instr2 <= rom[rom_addr_p1];
    end

    function automatic logic [31:0] rom_at(input logic [31:0] pc);
        logic [9:0] w;
        w = pc[11:2];
        return rom[w];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ordered list of {pc, instr} plus one pending pair request.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_rpc;
    bit          m_rv;
    bit          m_live = 1'b0;

    always @(negedge clk) begin
        bit          ev0, ev1, iss;
        int          n;
        logic [31:0] fa;
        if (m_live) begin
            ev0 = (mq.size() >= 1) && !redirect_valid;
            ev1 = (mq.size() >= 2) && !redirect_valid;
            fa  = {22'd0, m_fpc[11:2]};
            check("m_valid0", {31'd0, dec_valid0}, {31'd0, ev0});
            check("m_valid1", {31'd0, dec_valid1}, {31'd0, ev1});
            check("m_instr0", dec_instr0, ev0 ? mq[0].instr : NOP_INSTR);
            check("m_pc0",    dec_pc0,    ev0 ? mq[0].pc : 32'd0);
            check("m_instr1", dec_instr1, ev1 ? mq[1].instr : NOP_INSTR);
            check("m_pc1",    dec_pc1,    ev1 ? mq[1].pc : 32'd0);
            check("m_rom_addr", {22'd0, rom_addr}, fa);
        end
        if (rst_n === 1'b0) begin
            mq.delete();
            m_fpc  = 32'h0;
            m_rv   = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            if (redirect_valid) begin
                mq.delete();
                m_rv  = 1'b0;
                m_fpc = {redirect_pc[31:2], 2'b00};
            end else begin
                iss = (mq.size() + (m_rv ? 2 : 0) + 2) <= QD;
                n = 0;
                if (dec_ready && mq.size() >= 1) n = (mq.size() >= 2) ? 2 : 1;
                repeat (n) void'(mq.pop_front());
                if (m_rv) begin
                    mq.push_back('{pc: m_rpc,         instr: rom_at(m_rpc)});
                    mq.push_back('{pc: m_rpc + 32'd4, instr: rom_at(m_rpc + 32'd4)});
                end
                if (mq.size() > QD) check("m_overflow", mq.size(), QD);
                if (iss) begin
                    m_rv  = 1'b1;
                    m_rpc = m_fpc;
                    m_fpc = m_fpc + 32'd8;
                end else begin
                    m_rv = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) rom[k] = 32'hC000_0003 | (k << 8);
        rom[0]  = 32'h0010_0293;
        rom[1]  = 32'h0020_0313;
        rom[2]  = 32'h0030_0393;
        rom[3]  = 32'h0040_0413;
        rom[9]  = 32'h0053_0733;
        rom[10] = 32'h0063_87b3;

        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        dec_ready = 1'b1;
        repeat (2) tick();

        // Reset then stream
        rst_n = 1'b1;
        #3;
        check("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
        check("rst_valid0", {31'd0, dec_valid0}, 32'd0);
        check("rst_instr0", dec_instr0, 32'h0000_0013);
        check("rst_pc1", dec_pc1, 32'd0);
        tick(); #3;
        check("c2_valid0", {31'd0, dec_valid0}, 32'd0);
        tick(); #3;
        check("c3_pc0", dec_pc0, 32'h0);
        check("c3_instr0", dec_instr0, 32'h0010_0293);
        check("c3_pc1", dec_pc1, 32'h4);
        check("c3_instr1", dec_instr1, 32'h0020_0313);
        tick(); #3;
        check("c4_pc0", dec_pc0, 32'h8);
        check("c4_instr0", dec_instr0, 32'h0030_0393);
        check("c4_pc1", dec_pc1, 32'hC);
        check("c4_instr1", dec_instr1, 32'h0040_0413);
        repeat (5) tick();

        // Back-pressure after first pair
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick(); #3;
        check("bp_first_pc0", dec_pc0, 32'h0);
        tick();
        dec_ready = 1'b0;
        repeat (9) tick();
        #3;
        check("bp_hold_pc0", dec_pc0, 32'h8);
        check("bp_hold_valid1", {31'd0, dec_valid1}, 32'd1);
        tick();
        dec_ready = 1'b1;
        #3;
        check("bp_rel_pc0", dec_pc0, 32'h8);
        check("bp_rel_pc1", dec_pc1, 32'hC);
        tick(); #3;
        check("bp_next_pc0", dec_pc0, 32'h10);

        // Odd-word redirect while streaming
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h24;
        #3;
        check("rd_same_valid0", {31'd0, dec_valid0}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #3;
        check("rd_t1_valid0", {31'd0, dec_valid0}, 32'd0);
        tick(); tick(); #3;
        check("rd_t3_pc0", dec_pc0, 32'h24);
        check("rd_t3_instr0", dec_instr0, 32'h0053_0733);
        check("rd_t3_pc1", dec_pc1, 32'h28);
        check("rd_t3_instr1", dec_instr1, 32'h0063_87b3);

        // Redirect with full queue and dec_ready high
        tick();
        dec_ready = 1'b0;
        repeat (12) tick();
        dec_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        #3;
        check("rf_same_valid0", {31'd0, dec_valid0}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #3;
        check("rf_t1_valid0", {31'd0, dec_valid0}, 32'd0);
        tick(); tick(); #3;
        check("rf_t3_pc0", dec_pc0, 32'h40);
        check("rf_t3_pc1", dec_pc1, 32'h44);

        // Address wrap, low target bits ignored
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFF;
        tick();
        redirect_valid = 1'b0;
        #3;
        check("wr_rom_addr_top", {22'd0, rom_addr}, 32'd1023);
        tick(); #3;
        check("wr_rom_addr_next", {22'd0, rom_addr}, 32'd1);
        tick(); #3;
        check("wr_pc0", dec_pc0, 32'hFFC);
        check("wr_pc1", dec_pc1, 32'h1000);
        check("wr_instr0", dec_instr0, 32'hC003_FF03);
        check("wr_instr1", dec_instr1, 32'h0010_0293);

        // Reset mid-operation with a full queue
        tick();
        dec_ready = 1'b0;
        repeat (10) tick();
        dec_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #3;
        check("mr_valid0", {31'd0, dec_valid0}, 32'd0);
        check("mr_rom_addr", {22'd0, rom_addr}, 32'd0);
        tick(); tick(); #3;
        check("mr_pc0", dec_pc0, 32'h0);
        check("mr_instr0", dec_instr0, 32'h0010_0293);
        check("mr_pc1", dec_pc1, 32'h4);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_fetch.md
# dual_fetch

Dual-issue instruction fetch stage placed between the instruction ROM and decode. It owns the fetch PC and drives the ROM word address. It captures the two instructions the ROM returns one cycle later into a circular instruction queue, tagging each with its PC. It presents up to two instructions per cycle to decode and handles decode back-pressure and branch/jump redirects with flush of queued and in-flight instructions.

## Interface
- QDEPTH, 8: queue entries; power of two, minimum 4.
- RESET_PC, 32'h0000_0000: fetch PC after reset; word aligned.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- rom_addr  out  10  ROM word address, equal to fetch_pc[11:2].
- rom_instr1  in  32  ROM word at rom_addr; valid the cycle after the address is issued.
- rom_instr2  in  32  ROM word at rom_addr+1; same timing as rom_instr1.
- redirect_valid  in  1  redirect request from execute (taken branch/JAL).
- redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 0.
- dec_ready  in  1  decode accepts every valid slot this cycle.
- dec_valid0, dec_valid1  out  1 each  slot valid; dec_valid1 implies dec_valid0.
- dec_instr0, dec_instr1  out  32 each  instruction; 32'h00000013 (NOP) when the slot is invalid.
- dec_pc0, dec_pc1  out  32 each  slot PC; 0 when the slot is invalid.

## Operation
- **State.** fetch_pc (32b), req_valid/req_pc (one in-flight ROM request), queue of {pc, instr} entries, rd_ptr/wr_ptr (log2 QDEPTH bits, wrap modulo QDEPTH), count (log2 QDEPTH + 1 bits).
- **Request.** A request is issued in a cycle when redirect_valid=0 and count + 2·req_valid + 2 ≤ QDEPTH. No credit is taken for same-cycle pops.
  - On issue: req_valid<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+8 (32-bit wrap).
  - Otherwise req_valid<=0.
- **Return.** When req_valid=1 and redirect_valid=0, push two entries: {req_pc, rom_instr1}, then {req_pc+4, rom_instr2}.
- **Pop.** When dec_ready=1 and dec_valid0=1, pop 1 entry, or 2 entries if dec_valid1=1.
- **Valid flags.** dec_valid0 = count≥1 and !redirect_valid. dec_valid1 = count≥2 and !redirect_valid.
- **Same-cycle push and pop** are legal. count updates by +push−pop.
- **Redirect** (highest priority after reset), in the cycle redirect_valid=1:
  - no pop and no push;
  - queue cleared (pointers and count to 0);
  - in-flight request squashed (req_valid<=0);
  - fetch_pc<=redirect_pc with bits [1:0] forced to 0.
- **Odd-word targets.** A target that is not 8-byte aligned is legal; the pair starts at that word.
- **ROM wrap.** rom_addr wraps modulo 1024. Handling of rom_addr+1 overflow belongs to the ROM. PC tags are never truncated.
- **Reset.** The cycle rst_n=0 is sampled, on that edge:
  - fetch_pc<=RESET_PC;
  - queue empty;
  - req_valid<=0, so ROM data from a pre-reset request is discarded.
  - Reset dominates redirect.

## Timing
- **Reset values.** rom_addr=RESET_PC[11:2], dec_valid0/1=0, dec_instr0/1=32'h00000013, dec_pc0/1=0.
- **Outputs.** dec_* are combinational from the queue head (rd_ptr, rd_ptr+1), gated by redirect_valid. rom_addr is combinational from the fetch_pc register.
- **Startup latency.** rst_n released at edge E0:
  - cycle 1: request issued;
  - E1: ROM latches;
  - cycle 2: data present, pushed at E2;
  - cycle 3: dec_valid0/1=1.
- **Redirect latency.** Redirect in cycle t gives the first valid target pair in cycle t+3.
- **Throughput.** Steady state with dec_ready=1 and QDEPTH≥8 is one pair per cycle. QDEPTH=4 is functional but rate-limited.
- **Full queue.** The request rule guarantees pushes never overflow. No push is ever dropped except by redirect or reset.

## Structure
- Shared package cpu_pkg holds:
  - NOP_INSTR = 32'h00000013;
  - XLEN = 32;
  - ROM_AW = 10;
  - fetch-entry struct {pc[31:0], instr[31:0]}.
- The queue is one sub-module, fetch_queue, a circular buffer with 2 write ports, 2 read ports, flush, and count output.
- dual_fetch contains the PC register, request/credit logic, and redirect control.

## Test plan
1. **Reset then stream.** Apply reset, release, hold dec_ready=1 with the addi/add test program loaded.
   - Cycle 3: pc0=0x0/0x00100293 and pc1=0x4/0x00200313.
   - Cycle 4: 0x8/0x00300393 and 0xC/0x00400413.
   - Each following cycle advances by one pair.
2. **Back-pressure.** Drop dec_ready for 10 cycles after the first pair.
   - count saturates at 8 and requests stop.
   - On release, PCs continue 0x00,0x04,0x08,… with no gap or duplicate.
3. **Odd-word redirect.** Redirect to 0x24 while streaming.
   - Same cycle: dec_valid0=0.
   - 3 cycles later: pair 0x24/0x00530733 and 0x28/0x006387b3.
   - In-flight data is never presented.
4. **Redirect with full queue and dec_ready=1.** No handshake that cycle; count=0 the next cycle; target pair appears at t+3.
5. **Address wrap.** Redirect to 0xFFC.
   - rom_addr=1023; slot PCs 0xFFC and 0x1000.
   - Next request has rom_addr=1 and fetch_pc 0x1004.
6. **Reset mid-operation.** Assert rst_n=0 with a full queue and a request in flight.
   - Next cycle: dec_valid=0 and rom_addr=0.
   - After release, the stream restarts at PC 0 with no stale entries.
